// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - multiplexed 4-digit MM.SS 7-segment driver with adjust-mode blink
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  input  logic       twohz_clk,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [6:0]    DASH    = 7'b0111111;
  localparam logic [6:0]    BLANK   = 7'b1111111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [5:0]    snap_min;
  logic [5:0]    snap_sec;
  logic          fresh;
  logic          blink_meta;
  logic          blink;

  logic          wrap;
  logic [5:0]    field;
  logic [5:0]    digit;
  logic          dash;
  logic          blank;
  logic          dp;
  logic [7:0]    seg_nxt;
  logic [3:0]    an_nxt;

  // active-low segment pattern for one decimal digit
  function automatic logic [6:0] enc(input logic [5:0] d);
    case (d)
      6'd0:    enc = 7'b1000000;
      6'd1:    enc = 7'b1111001;
      6'd2:    enc = 7'b0100100;
      6'd3:    enc = 7'b0110000;
      6'd4:    enc = 7'b0011001;
      6'd5:    enc = 7'b0010010;
      6'd6:    enc = 7'b0000010;
      6'd7:    enc = 7'b1111000;
      6'd8:    enc = 7'b0000000;
      6'd9:    enc = 7'b0010000;
      default: enc = BLANK;
    endcase
  endfunction

  assign wrap = (cnt == CNT_MAX);

  // slot timing, digit index and per-frame snapshot of the time value
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      idx      <= 2'd0;
      snap_min <= 6'd0;
      snap_sec <= 6'd0;
      fresh    <= 1'b1;
    end else begin
      if (wrap) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (fresh || (wrap && idx == 2'd3)) begin
        snap_min <= minutes;
        snap_sec <= seconds;
      end
      fresh <= 1'b0;
    end
  end

  // bring the asynchronous 2 Hz blink phase into the clk domain
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_meta <= 1'b0;
      blink      <= 1'b0;
    end else begin
      blink_meta <= twohz_clk;
      blink      <= blink_meta;
    end
  end

  // pick the digit for the current slot and build its cathode/anode pattern
  always_comb begin
    field   = idx[1] ? snap_min : snap_sec;
    digit   = idx[0] ? (field / 6'd10) : (field % 6'd10);
    dash    = (field >= 6'd60);
    blank   = adj && blink && (sel ? !idx[1] : idx[1]);
    dp      = (idx != 2'd2);
    seg_nxt = 8'hFF;
    an_nxt  = 4'b1111;
    if (cnt >= GUARD_C) begin
      an_nxt = ~(4'b0001 << idx);
      if (!blank) begin
        seg_nxt = {dp, dash ? DASH : enc(digit)};
      end
    end
  end

  // registered display pins
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= 8'hFF;
      an  <= 4'b1111;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule
